// File: rtl/in_packet_sched_pkg.sv
// Shared definitions for the IN packet scheduler.
//   PID_DATA0 / PID_DATA1 : data PID encodings driven on tx_pid
//   state_e               : scheduler FSM state encoding
package in_packet_sched_pkg;

  localparam logic [3:0] PID_DATA0 = 4'b0011;
  localparam logic [3:0] PID_DATA1 = 4'b1011;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FILL    = 3'd1,
    ST_SEND    = 3'd2,
    ST_WAIT_HS = 3'd3,
    ST_NAK     = 3'd4
  } state_e;

endpackage

// File: rtl/in_packet_sched_pkt_buf.sv
// Packet payload buffer: DEPTH x 8, one synchronous write port and one
// asynchronous read port. Contents are deliberately not reset.
//   clk   : clock
//   we    : write enable
//   waddr : write address
//   wdata : write data
//   raddr : read address
//   rdata : combinational read data
module pkt_buf #(
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);

  logic [7:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/in_packet_sched.sv
// USB-style IN endpoint packet scheduler. On a host IN token it either
// NAKs (nothing to send), fills a packet buffer from the byte queue, or
// retransmits a still-unacknowledged packet; it then streams the packet to
// the serializer and waits for the host ACK (or a timeout).
//   clk, rst            : clock, synchronous active-high reset
//   in_token            : host IN token pulse
//   q_empty, q_data     : byte queue status / read data
//   q_rd                : byte queue read strobe (single-cycle pulses)
//   tx_valid/ready/data : payload byte stream to the serializer
//   tx_last, tx_pid     : last-byte marker, data PID (DATA0/DATA1)
//   nak                 : NAK handshake request pulse
//   ack_rcvd            : host ACK pulse
//   busy                : scheduler not idle
module in_packet_sched
  import in_packet_sched_pkg::*;
#(
  parameter int MAX_PKT  = 64,
  parameter int TOUT_CYC = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_token,
  input  logic       q_empty,
  input  logic [7:0] q_data,
  output logic       q_rd,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic [7:0] tx_data,
  output logic       tx_last,
  output logic [3:0] tx_pid,
  output logic       nak,
  input  logic       ack_rcvd,
  output logic       busy
);

  localparam int              AW        = (MAX_PKT > 1) ? $clog2(MAX_PKT) : 1;
  localparam int              TW        = $clog2(TOUT_CYC + 1);
  localparam logic [6:0]      LEN_MAX   = 7'(MAX_PKT);
  localparam logic [TW-1:0]   TOUT_LAST = TW'(TOUT_CYC - 1);

  state_e          state_q, state_d;
  logic [3:0]      pid_q,   pid_d;
  logic            pend_q,  pend_d;   // buffer holds an unacknowledged packet
  logic [6:0]      len_q,   len_d;    // bytes captured into the buffer
  logic [6:0]      idx_q,   idx_d;    // next byte to present in SEND
  logic            cap_q,   cap_d;    // FILL: this cycle captures q_data
  logic [TW-1:0]   tout_q,  tout_d;

  logic            buf_we;
  logic [7:0]      buf_rdata;

  pkt_buf #(.DEPTH(MAX_PKT), .AW(AW)) u_buf (
    .clk   (clk),
    .we    (buf_we),
    .waddr (len_q[AW-1:0]),
    .wdata (q_data),
    .raddr (idx_q[AW-1:0]),
    .rdata (buf_rdata)
  );

  always_comb begin
    state_d  = state_q;
    pid_d    = pid_q;
    pend_d   = pend_q;
    len_d    = len_q;
    idx_d    = idx_q;
    cap_d    = cap_q;
    tout_d   = tout_q;
    q_rd     = 1'b0;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    tx_last  = 1'b0;
    nak      = 1'b0;
    buf_we   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        idx_d  = '0;
        cap_d  = 1'b0;
        tout_d = '0;
        if (in_token) begin
          if (pend_q)       state_d = ST_SEND;
          else if (q_empty) state_d = ST_NAK;
          else begin
            state_d = ST_FILL;
            len_d   = '0;
          end
        end
      end

      // Alternates read-strobe and capture cycles so q_rd always has a low
      // cycle between pulses. The first read is unconditional (queue was
      // non-empty at the token), which guarantees no zero-length packet.
      ST_FILL: begin
        if (cap_q) begin
          buf_we = 1'b1;
          len_d  = (len_q == LEN_MAX) ? len_q : len_q + 7'd1;
          cap_d  = 1'b0;
        end else if ((len_q != 7'd0) && (q_empty || (len_q == LEN_MAX))) begin
          state_d = ST_SEND;
          pend_d  = 1'b1;
          idx_d   = '0;
        end else begin
          q_rd  = 1'b1;
          cap_d = 1'b1;
        end
      end

      ST_SEND: begin
        tx_valid = 1'b1;
        tx_data  = buf_rdata;
        tx_last  = (idx_q == len_q - 7'd1);
        if (tx_ready) begin
          if (tx_last) begin
            state_d = ST_WAIT_HS;
            tout_d  = '0;
          end else begin
            idx_d = idx_q + 7'd1;
          end
        end
      end

      // ACK wins over a coincident timeout. On timeout the buffer, length
      // and pending flag are kept so the next token retransmits as-is.
      ST_WAIT_HS: begin
        if (ack_rcvd) begin
          pid_d   = (pid_q == PID_DATA0) ? PID_DATA1 : PID_DATA0;
          pend_d  = 1'b0;
          len_d   = '0;
          state_d = ST_IDLE;
        end else if (tout_q == TOUT_LAST) begin
          state_d = ST_IDLE;
        end else begin
          tout_d = tout_q + 1'b1;
        end
      end

      ST_NAK: begin
        nak     = 1'b1;
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      pid_q   <= PID_DATA0;
      pend_q  <= 1'b0;
      len_q   <= '0;
      idx_q   <= '0;
      cap_q   <= 1'b0;
      tout_q  <= '0;
    end else begin
      state_q <= state_d;
      pid_q   <= pid_d;
      pend_q  <= pend_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      cap_q   <= cap_d;
      tout_q  <= tout_d;
    end
  end

  assign busy   = (state_q != ST_IDLE);
  assign tx_pid = pid_q;

endmodule

// File: tb/tb_in_packet_sched.sv
module tb_in_packet_sched;
  import in_packet_sched_pkg::*;

  localparam int MAXP = 64;
  localparam int TOUT = 40;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_token = 1'b0;
  logic       q_empty = 1'b1;
  logic [7:0] q_data = 8'h00;
  logic       q_rd;
  logic       tx_valid;
  logic       tx_ready = 1'b0;
  logic [7:0] tx_data;
  logic       tx_last;
  logic [3:0] tx_pid;
  logic       nak;
  logic       ack_rcvd = 1'b0;
  logic       busy;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  always #5 clk = ~clk;

  in_packet_sched #(.MAX_PKT(MAXP), .TOUT_CYC(TOUT)) dut (
    .clk(clk), .rst(rst), .in_token(in_token), .q_empty(q_empty),
    .q_data(q_data), .q_rd(q_rd), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .tx_data(tx_data), .tx_last(tx_last), .tx_pid(tx_pid), .nak(nak),
    .ack_rcvd(ack_rcvd), .busy(busy)
  );

  // Byte queue seen by the DUT: a read strobe presents the popped byte on
  // the following cycle. Pushes are staged through push_arr so only this
  // process touches the queue and q_empty.
  logic [7:0] fifo[$];
  logic [7:0] push_arr [0:2047];
  int push_wr = 0;
  int push_rd = 0;

  always @(posedge clk) begin
    if (q_rd && fifo.size() > 0) q_data <= fifo.pop_front();
    while (push_rd < push_wr) begin
      fifo.push_back(push_arr[push_rd]);
      push_rd++;
    end
    q_empty <= (fifo.size() == 0);
  end

  // Monitor: record accepted bytes and strobe cycles.
  int         cyc = 0;
  logic [7:0] got_b[$];
  bit         got_l[$];
  logic [3:0] got_p[$];
  int         rd_cyc[$];
  int         nak_cyc[$];
  int         last_cnt = 0;
  int         txv_cnt = 0;

  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      if (tx_valid && tx_ready) begin
        got_b.push_back(tx_data);
        got_l.push_back(tx_last);
        got_p.push_back(tx_pid);
        if (tx_last) last_cnt++;
      end
      if (tx_valid) txv_cnt++;
      if (q_rd) rd_cyc.push_back(cyc);
      if (nak) nak_cyc.push_back(cyc);
    end
  end

  // Reference model: queue contents, pending packet, current PID.
  logic [7:0] mfifo[$];
  logic [7:0] mpend[$];
  bit         mpend_v = 1'b0;
  logic [3:0] mpid = PID_DATA0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] b);
    push_arr[push_wr] = b;
    push_wr++;
    mfifo.push_back(b);
  endtask

  task automatic run_token(input bit do_ack, input bit rnd, input string nm);
    logic [7:0] exp[$];
    logic [3:0] ep;
    bit from_q;
    int sb, rs, l0, n, bad, w;
    ep     = mpid;
    from_q = !mpend_v;
    if (mpend_v) exp = mpend;
    else begin
      while (mfifo.size() > 0 && exp.size() < MAXP) exp.push_back(mfifo.pop_front());
      mpend   = exp;
      mpend_v = 1'b1;
    end
    sb = got_b.size(); rs = rd_cyc.size(); l0 = last_cnt;
    in_token = 1'b1; tick(); in_token = 1'b0;
    w = 0;
    while (last_cnt == l0 && w < 3000) begin
      tx_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      tick();
      w++;
    end
    tx_ready = 1'b0;
    chk_cnt++;
    if (last_cnt == l0) $display("FAIL %s send_done: no tx_last accepted in %0d cycles", nm, w);
    else pass_cnt++;
    if (do_ack) begin
      tick(); tick();
      ack_rcvd = 1'b1; tick(); ack_rcvd = 1'b0;
      mpid    = (mpid == PID_DATA0) ? PID_DATA1 : PID_DATA0;
      mpend_v = 1'b0;
      mpend.delete();
    end
    w = 0;
    while (busy && w < TOUT + 20) begin tick(); w++; end
    chk_cnt++;
    if (busy !== 1'b0) $display("FAIL %s idle: busy=%b required 0", nm, busy);
    else pass_cnt++;
    if (!do_ack) begin
      chk_cnt++;
      if (w < TOUT - 2 || w > TOUT + 2)
        $display("FAIL %s timeout: waited %0d cycles required about %0d", nm, w, TOUT);
      else pass_cnt++;
    end
    n = got_b.size() - sb;
    chk_cnt++;
    if (n !== exp.size()) $display("FAIL %s length: got %0d required %0d", nm, n, exp.size());
    else pass_cnt++;
    bad = 0;
    for (int i = 0; i < n; i++) begin
      if (i < exp.size() && got_b[sb+i] !== exp[i]) bad++;
      if (got_l[sb+i] !== (i == n - 1)) bad++;
      if (got_p[sb+i] !== ep) bad++;
    end
    chk_cnt++;
    if (bad != 0) $display("FAIL %s content: %0d byte/last/pid errors (pid %h required %h)",
                           nm, bad, (n > 0) ? got_p[sb] : 4'h0, ep);
    else pass_cnt++;
    chk_cnt++;
    if ((rd_cyc.size() - rs) != (from_q ? exp.size() : 0))
      $display("FAIL %s q_rd_count: got %0d required %0d", nm, rd_cyc.size() - rs,
               from_q ? exp.size() : 0);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    rst = 1'b1; tick(); tick(); tick();
    chk_cnt++;
    if ({q_rd, tx_valid, tx_last, nak, busy} !== 5'b0 || tx_data !== 8'h00)
      $display("FAIL reset_outputs: q_rd=%b tx_valid=%b tx_last=%b nak=%b busy=%b tx_data=%h required all 0",
               q_rd, tx_valid, tx_last, nak, busy, tx_data);
    else pass_cnt++;
    chk_cnt++;
    if (tx_pid !== PID_DATA0) $display("FAIL reset_pid: got %h required %h", tx_pid, PID_DATA0);
    else pass_cnt++;
    rst = 1'b0; tick();
  endtask

  task automatic test_nak();
    int nb, rs, v0;
    // Stray ACK while idle must not toggle the PID (model leaves mpid alone).
    ack_rcvd = 1'b1; tick(); ack_rcvd = 1'b0; tick();
    nb = nak_cyc.size(); rs = rd_cyc.size(); v0 = txv_cnt;
    in_token = 1'b1; tick(); in_token = 1'b0;
    repeat (5) tick();
    chk_cnt++;
    if (nak_cyc.size() - nb != 1) $display("FAIL nak_pulse: %0d nak cycles required 1", nak_cyc.size() - nb);
    else pass_cnt++;
    chk_cnt++;
    if (rd_cyc.size() - rs != 0 || txv_cnt != v0)
      $display("FAIL nak_quiet: q_rd=%0d tx_valid=%0d cycles required 0", rd_cyc.size() - rs, txv_cnt - v0);
    else pass_cnt++;
    chk_cnt++;
    if (busy !== 1'b0) $display("FAIL nak_idle: busy=%b required 0", busy);
    else pass_cnt++;
  endtask

  task automatic test_basic();
    int rs, bad;
    push(8'hA1); push(8'hB2); push(8'hC3);
    tick(); tick();
    rs = rd_cyc.size();
    run_token(1'b1, 1'b0, "basic");
    bad = 0;
    for (int i = rs + 1; i < rd_cyc.size(); i++)
      if (rd_cyc[i] - rd_cyc[i-1] != 2) bad++;
    chk_cnt++;
    if (bad != 0) $display("FAIL basic_rd_spacing: %0d gaps not equal to 2 cycles", bad);
    else pass_cnt++;
  endtask

  task automatic test_max();
    for (int i = 0; i < 70; i++) push(8'($urandom));
    tick(); tick();
    run_token(1'b1, 1'b0, "max_first");
    run_token(1'b1, 1'b0, "max_second");
  endtask

  task automatic test_timeout();
    push(8'($urandom)); push(8'($urandom));
    tick(); tick();
    run_token(1'b0, 1'b0, "tout_first");
    run_token(1'b1, 1'b0, "tout_retx");
    push(8'($urandom));
    tick(); tick();
    run_token(1'b1, 1'b0, "tout_after");
  endtask

  task automatic test_random_ready();
    for (int k = 0; k < 6; k++) begin
      int len = $urandom_range(1, 80);
      for (int i = 0; i < len; i++) push(8'($urandom));
      tick(); tick();
      run_token(1'b1, 1'b1, $sformatf("rand%0d", k));
    end
  endtask

  task automatic test_rst_mid_send();
    int sb, w;
    while (mfifo.size() > 0) run_token(1'b1, 1'b1, "drain");
    if (mpid == PID_DATA0) begin
      push(8'h5A); tick(); tick();
      run_token(1'b1, 1'b0, "rst_pre");
    end
    for (int i = 0; i < 5; i++) push(8'($urandom));
    tick(); tick();
    for (int i = 0; i < 5; i++) void'(mfifo.pop_front());
    sb = got_b.size();
    in_token = 1'b1; tick(); in_token = 1'b0;
    tx_ready = 1'b1;
    w = 0;
    while (got_b.size() == sb && w < 200) begin tick(); w++; end
    chk_cnt++;
    if (got_b.size() == sb) $display("FAIL rst_send_start: no byte accepted in %0d cycles", w);
    else pass_cnt++;
    rst = 1'b1; tick(); rst = 1'b0; tx_ready = 1'b0;
    chk_cnt++;
    if ({q_rd, tx_valid, tx_last, nak, busy} !== 5'b0 || tx_data !== 8'h00)
      $display("FAIL rst_mid_send: q_rd=%b tx_valid=%b tx_last=%b nak=%b busy=%b tx_data=%h required all 0",
               q_rd, tx_valid, tx_last, nak, busy, tx_data);
    else pass_cnt++;
    chk_cnt++;
    if (tx_pid !== PID_DATA0) $display("FAIL rst_mid_send_pid: got %h required %h", tx_pid, PID_DATA0);
    else pass_cnt++;
    mpend_v = 1'b0; mpend.delete(); mpid = PID_DATA0;
    tick();
    push(8'($urandom)); push(8'($urandom));
    tick(); tick();
    run_token(1'b1, 1'b1, "post_rst");
  endtask

  initial begin
    test_reset();
    test_nak();
    test_basic();
    test_max();
    test_timeout();
    test_random_ready();
    test_rst_mid_send();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", pass_cnt, chk_cnt);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/in_packet_sched.md
IN_PACKET_SCHED -- requirements
Module: in_packet_sched

Interface
REQ-001 SHALL have parameter MAX_PKT, default 64, maximum payload bytes per IN packet (legal range 1..64).
REQ-002 SHALL have parameter TOUT_CYC, default 1000, handshake timeout in clk cycles after the last byte is accepted.
REQ-003 SHALL provide port clk, input, 1, the only clock; all logic on its rising edge.
REQ-004 SHALL provide port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL provide port in_token, input, 1, one-cycle pulse: host IN token addressed to this endpoint.
REQ-006 SHALL provide port q_empty, input, 1, byte queue empty flag.
REQ-007 SHALL provide port q_data, input, 8, byte queue read data.
REQ-008 SHALL provide port q_rd, output, 1, one-cycle read strobe to the byte queue.
REQ-009 SHALL provide port tx_valid, output, 1, packet byte valid toward the PHY serializer.
REQ-010 SHALL provide port tx_ready, input, 1, serializer accepts the byte when tx_valid and tx_ready are both high.
REQ-011 SHALL provide port tx_data, output, 8, packet payload byte.
REQ-012 SHALL provide port tx_last, output, 1, marks the final payload byte.
REQ-013 SHALL provide port tx_pid, output, 4, data PID: 4'b0011 DATA0, 4'b1011 DATA1; stable while tx_valid is high.
REQ-014 SHALL provide port nak, output, 1, one-cycle pulse requesting a NAK handshake.
REQ-015 SHALL provide port ack_rcvd, input, 1, one-cycle pulse: host ACK received.
REQ-016 SHALL provide port busy, output, 1, high in every state except IDLE.

Function
REQ-017 SHALL implement states IDLE, FILL, SEND, WAIT_HS and NAK.
REQ-018 IDLE + in_token: pending packet held -> SEND; else q_empty high -> NAK; else -> FILL.
REQ-019 SHALL ignore in_token in every state except IDLE.
REQ-020 NAK SHALL assert nak for exactly one cycle, then return to IDLE.
REQ-021 FILL: q_rd SHALL be a single-cycle pulse followed by at least one low cycle, because the queue edge-detects its read strobe.
REQ-022 FILL SHALL capture q_data into the packet buffer on the cycle after each q_rd pulse.
REQ-023 FILL SHALL evaluate q_empty on the cycle after capture: if empty or length equals MAX_PKT -> SEND; else issue the next q_rd. Throughput is one byte per 2 cycles.
REQ-024 SEND SHALL present buffer bytes in order from index 0, advance only on a valid&ready cycle, and assert tx_last with byte length-1.
REQ-025 SHALL go SEND -> WAIT_HS on the cycle after tx_last is accepted; tx_valid SHALL drop in that cycle.
REQ-026 WAIT_HS + ack_rcvd SHALL toggle the data PID, clear the pending flag and return to IDLE.
REQ-027 WAIT_HS with no ACK for TOUT_CYC cycles SHALL keep the buffer and pending flag, keep the PID unchanged, and return to IDLE; the next token retransmits identical bytes and PID without reading the queue.
REQ-028 ack_rcvd in the same cycle as timeout expiry SHALL be treated as ACK.
REQ-029 ack_rcvd outside WAIT_HS SHALL be ignored.
REQ-030 A packet SHALL never be zero-length; no ZLP is generated after a MAX_PKT-length packet.
REQ-031 The length counter SHALL be 7 bits, saturating at MAX_PKT, with no wrap.

Reset
REQ-032 On rst SHALL enter IDLE, set PID to DATA0, clear the pending flag and length, and drive q_rd, tx_valid, tx_last, nak and busy to 0 and tx_data to 0.
REQ-033 rst mid-FILL or mid-SEND SHALL discard the partial packet; bytes already read from the queue are lost by design.
REQ-034 Buffer RAM contents SHALL not be reset.

Structure
REQ-035 A shared package SHALL hold the PID_DATA0 and PID_DATA1 constants and the state encoding.
REQ-036 One sub-module pkt_buf SHALL provide a MAX_PKT x 8 buffer with one write port and one asynchronous-read port.

Verification
REQ-037 Token with q_empty=1 -> nak high exactly 1 cycle, no q_rd pulse, no tx_valid.
REQ-038 Queue holds 3 bytes A1,B2,C3, then token -> 3 q_rd pulses spaced 2 cycles; tx bytes A1,B2,C3 with tx_last on C3; tx_pid=4'b0011.
REQ-039 Queue holds 70 bytes, token+ACK then token+ACK -> first packet 64 bytes on DATA0, second packet 6 bytes on DATA1.
REQ-040 Send 2 bytes, withhold ACK for TOUT_CYC, then token -> same 2 bytes and same PID with zero q_rd pulses; after ACK the PID toggles.
REQ-041 tx_ready toggled randomly during SEND -> byte order is preserved and no byte is duplicated.
REQ-042 rst asserted mid-SEND -> next cycle all outputs are 0 and state is IDLE; the next packet uses DATA0.
